bram_burst_reader: RTL and testbench
====================================

Name: bram_burst_reader

Overview:
- Streaming read engine placed directly downstream of the BRAM block.
- On a start command it reads `length` consecutive words beginning at `start_address`, driving the BRAM's ram_enable/address inputs and capturing its registered output_data.
- Captured words go into a small FIFO and are presented on a valid/ready stream, so consumers may apply backpressure without losing data.

Parameters:
- RAM_WIDTH, 32: data word width; must match the BRAM.
- RAM_ADDR_BITS, 9: BRAM address width; must match the BRAM.
- FIFO_DEPTH, 4: output buffer depth in words; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; honoured only while busy=0.
- start_address  in  RAM_ADDR_BITS  first word address; sampled with start.
- length  in  RAM_ADDR_BITS+1  word count, 0 to 2^RAM_ADDR_BITS; sampled with start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at burst completion.
- ram_enable  out  1  to BRAM ram_enable.
- write_enable  out  1  to BRAM write_enable; constant 0.
- address  out  RAM_ADDR_BITS  to BRAM address.
- ram_data  in  RAM_WIDTH  from BRAM output_data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  RAM_WIDTH  stream word, FIFO head.
- out_last  out  1  high with the final word of the burst.

Behaviour:
- Interface: one clock, named clock; reset is asynchronous and active-low, named reset_n.
- Reset values: every output is 0, the FIFO is empty, in-flight tracking is cleared and the state is IDLE.
- Reset asserted mid-burst aborts the burst. No done pulse is produced, and the first start after release runs normally.
- BRAM timing:
  - ram_enable=1 with address A in cycle c means ram_data holds mem[A] in cycle c+1.
  - The reader writes that word into the FIFO at the end of cycle c+1.
  - ram_enable is deasserted on every cycle that does not issue a read, so BRAM output is never consumed twice.
- State machine:
  - IDLE: busy=0. On start=1 the block latches address and remaining count.
    - length=0: go to DONE.
    - Otherwise: go to READ.
  - READ: a read issues when remaining>0 and (fifo_count + in_flight − pop_this_cycle) < FIFO_DEPTH.
    - Each issue increments address and decrements remaining.
    - When the last read has been issued, go to DRAIN.
  - DRAIN: wait until in_flight=0, the FIFO is empty, and the last word has been handshaken; then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- Latency and throughput:
  - First out_valid is asserted 2 cycles after the edge that samples start.
  - With out_ready held high, the block sustains one word per cycle.
- Address arithmetic is modulo 2^RAM_ADDR_BITS: address 2^RAM_ADDR_BITS−1 is followed by 0.
- Stream rules:
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - A word transfers when out_valid and out_ready are both 1.
  - out_valid never deasserts without a transfer.
- out_last is tagged at capture time on the word whose read was the final issue of the burst.
- FIFO:
  - Never overflows: the credit check guarantees space for every in-flight read.
  - A push and a pop in the same cycle are both honoured.
- start while busy=1, or during the DONE cycle, is ignored: no latch and no side effects.
- ram_enable, address and the stream outputs are driven from registers; there are no combinational paths from out_ready to ram_enable.

Test Plan:
- BRAM preloaded mem[i]=i*10; start, start_address=0, length=10, out_ready=1 -> words 0,10,...,90 on consecutive cycles; first out_valid 2 cycles after the start edge; out_last only on 90; done pulses once, 1 cycle after the 90 handshake.
- Same burst with out_ready toggled randomly and held low for 20 cycles mid-burst -> all 10 words in order with no duplicates; fifo_count+in_flight never exceeds 4; out_data stable while stalled.
- start_address=510, length=4 -> reads addresses 510,511,0,1; stream data mem[510],mem[511],mem[0],mem[1]; out_last on mem[1].
- length=0 -> ram_enable never asserted, out_valid never asserted; done pulses 1 cycle after the start edge, busy low throughout after that.
- A second start during a 10-word burst is ignored. Assert reset_n=0 after word 4 -> all outputs 0 immediately, no done. A new start (address 5, length 3) after release -> 50,60,70 with done.
- length=512, start_address=0, out_ready=1 -> 512 words in 512 consecutive cycles; out_last on mem[511]; write_enable 0 throughout.

Source files
------------

// File: rtl/bram_burst_reader.sv
// Streaming burst reader for a registered-output BRAM: issues credit-limited reads,
// buffers the returned words in a small FIFO and presents them on a valid/ready stream.
module bram_burst_reader #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] start_address,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_last
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    localparam logic [CW1-1:0]         DEPTH_W   = CW1'(FIFO_DEPTH);
    localparam logic [CW-1:0]          CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]          CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]          PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [RAM_ADDR_BITS:0] REM_ZERO  = {(RAM_ADDR_BITS+1){1'b0}};
    localparam logic [RAM_ADDR_BITS:0] REM_ONE   = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ram_enable;
    logic                     r_ram_last;
    logic                     r_cap_valid;
    logic                     r_cap_last;
    logic [RAM_ADDR_BITS-1:0] r_address;
    logic [RAM_ADDR_BITS-1:0] r_next_addr;
    logic [RAM_ADDR_BITS:0]   r_remaining;

    logic [RAM_WIDTH-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    r_fifo_last;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;

    logic                     w_load;
    logic                     w_issue;
    logic                     w_issue_last;
    logic                     w_push;
    logic                     w_pop;
    logic [CW1-1:0]           w_occ;
    logic                     w_credit;
    logic                     w_drain_done;
    logic [RAM_ADDR_BITS-1:0] w_issue_addr;

    assign busy         = r_busy;
    assign done         = r_done;
    assign ram_enable   = r_ram_enable;
    assign write_enable = 1'b0;
    assign address      = r_address;
    assign out_valid    = (r_count != CNT_ZERO);
    assign out_data     = r_fifo_data[r_rd_ptr];
    assign out_last     = r_fifo_last[r_rd_ptr];

    assign w_push       = r_cap_valid;
    assign w_pop        = out_valid & out_ready;
    assign w_issue_addr = w_load ? start_address : r_next_addr;

    // Credit: buffered words plus reads still in the BRAM pipeline must leave room for one more.
    assign w_occ    = {1'b0, r_count}
                    + {{CW{1'b0}}, r_ram_enable}
                    + {{CW{1'b0}}, r_cap_valid}
                    - {{CW{1'b0}}, w_pop};
    assign w_credit = (w_occ < DEPTH_W);

    // Burst is finished once nothing is in flight and the final word leaves this cycle (or already has).
    assign w_drain_done = !r_ram_enable && !r_cap_valid &&
                          ((r_count == CNT_ZERO) || ((r_count == CNT_ONE) && w_pop));

    // Next-state and read-issue decision for the following cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (length == REM_ZERO) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_last = (length == REM_ONE);
                        w_state_nxt  = (length == REM_ONE) ? S_DRAIN : S_READ;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if ((r_remaining != REM_ZERO) && w_credit) begin
                    w_issue      = 1'b1;
                    w_issue_last = (r_remaining == REM_ONE);
                    w_state_nxt  = (r_remaining == REM_ONE) ? S_DRAIN : S_READ;
                end else if (r_remaining == REM_ZERO) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with registered busy/done status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_READ) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // BRAM request side: address/count tracking and the two-stage in-flight pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_enable <= 1'b0;
            r_ram_last   <= 1'b0;
            r_cap_valid  <= 1'b0;
            r_cap_last   <= 1'b0;
            r_address    <= {RAM_ADDR_BITS{1'b0}};
            r_next_addr  <= {RAM_ADDR_BITS{1'b0}};
            r_remaining  <= REM_ZERO;
        end else begin
            r_ram_enable <= w_issue;
            r_ram_last   <= w_issue & w_issue_last;
            r_cap_valid  <= r_ram_enable;
            r_cap_last   <= r_ram_enable & r_ram_last;
            if (w_issue) begin
                r_address   <= w_issue_addr;
                r_next_addr <= w_issue_addr + ADDR_ONE;
            end else begin
                r_address   <= r_address;
                r_next_addr <= r_next_addr;
            end
            if (w_load) begin
                r_remaining <= w_issue ? (length - REM_ONE) : length;
            end else if (w_issue) begin
                r_remaining <= r_remaining - REM_ONE;
            end else begin
                r_remaining <= r_remaining;
            end
        end
    end

    // Output FIFO storage; the last flag travels with each captured word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= {RAM_WIDTH{1'b0}};
            end
            r_fifo_last <= {FIFO_DEPTH{1'b0}};
        end else if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_data;
            r_fifo_last[r_wr_ptr] <= r_cap_last;
        end else begin
            r_fifo_last <= r_fifo_last;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            r_wr_ptr <= w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed self-checking bench for bram_burst_reader with a behavioural registered-output BRAM.
module tb_bram_burst_reader;

    localparam int W  = 32;
    localparam int AB = 9;
    localparam int D  = 4;
    localparam int N  = 1 << AB;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AB-1:0] start_address = '0;
    logic [AB:0]   length = '0;
    logic          busy, done, ram_enable, write_enable;
    logic [AB-1:0] address;
    logic [W-1:0]  ram_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;

    logic [W-1:0]  mem [N];

    int total = 0;
    int bad   = 0;

    bram_burst_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .FIFO_DEPTH(D)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
        .length(length), .busy(busy), .done(done), .ram_enable(ram_enable),
        .write_enable(write_enable), .address(address), .ram_data(ram_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_enable) ram_data <= mem[address];
    end

    // Mid-cycle monitor: records handshakes, issued addresses, done pulses and stream-rule violations.
    int           cyc = 0;
    logic [W-1:0] rx_q[$];
    logic         rx_last_q[$];
    int           rx_cyc_q[$];
    logic [AB-1:0] addr_q[$];
    int           done_cnt = 0, done_cyc = -1, en_cnt = 0, vld_cnt = 0;
    int           stall_err = 0, occ = 0, max_occ = 0;
    logic         we_seen = 1'b0, p_stall = 1'b0, p_last = 1'b0;
    logic [W-1:0] p_data = '0;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            occ = 0;
            p_stall = 1'b0;
        end else begin
            if (p_stall && (!out_valid || out_data !== p_data || out_last !== p_last)) stall_err++;
            p_stall = out_valid && !out_ready;
            p_data  = out_data;
            p_last  = out_last;
            if (ram_enable) begin
                en_cnt++;
                occ++;
                addr_q.push_back(address);
            end
            if (occ > max_occ) max_occ = occ;
            if (out_valid) vld_cnt++;
            if (write_enable) we_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rx_last_q.push_back(out_last);
                rx_cyc_q.push_back(cyc);
                occ--;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [AB-1:0] a, input logic [AB:0] len, output int scyc);
        start = 1'b1;
        start_address = a;
        length = len;
        @(posedge clock);
        scyc = cyc;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),       32'd0);
        chk({tag, "_done"},   32'(done),       32'd0);
        chk({tag, "_ren"},    32'(ram_enable), 32'd0);
        chk({tag, "_wen"},    32'(write_enable), 32'd0);
        chk({tag, "_addr"},   32'(address),    32'd0);
        chk({tag, "_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_data"},   out_data,        32'd0);
        chk({tag, "_last"},   32'(out_last),   32'd0);
    endtask

    initial begin
        int sc, b, d0, e0, v0, a0, errs, nlast;
        for (int i = 0; i < N; i++) mem[i] = 32'(i * 10);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_outputs_zero("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Burst of 10 from address 0, consumer always ready
        out_ready = 1'b1;
        b = rx_q.size(); d0 = done_cnt;
        start_burst(9'd0, 10'd10, sc);
        wait_done("t1_done_seen", d0, 100);
        repeat (2) @(posedge clock);
        #1;
        chk("t1_count", 32'(rx_q.size() - b), 32'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("t1_word%0d", i), rx_q[b+i], 32'(i * 10));
        nlast = 0;
        for (int i = 0; i < 10; i++) nlast += int'(rx_last_q[b+i]);
        chk("t1_nlast", 32'(nlast), 32'd1);
        chk("t1_last_on_90", 32'(rx_last_q[b+9]), 32'd1);
        chk("t1_first_hs_cyc", 32'(rx_cyc_q[b]), 32'(sc + 3));
        chk("t1_last_hs_cyc", 32'(rx_cyc_q[b+9]), 32'(sc + 12));
        chk("t1_done_cyc", 32'(done_cyc), 32'(sc + 13));
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Same burst with random backpressure and a 20-cycle stall
        out_ready = 1'b0;
        b = rx_q.size(); d0 = done_cnt;
        start_burst(9'd0, 10'd10, sc);
        for (int j = 0; j < 400 && done_cnt == d0; j++) begin
            out_ready = (j >= 4 && j < 24) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        chk("t2_done_seen", 32'(done_cnt != d0), 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("t2_count", 32'(rx_q.size() - b), 32'd10);
        errs = 0;
        for (int i = 0; i < 10; i++) if (rx_q[b+i] !== 32'(i * 10)) errs++;
        chk("t2_data_errs", 32'(errs), 32'd0);
        chk("t2_last_on_90", 32'(rx_last_q[b+9]), 32'd1);
        chk("t2_stall_stable", 32'(stall_err), 32'd0);
        chk("t2_occ_le_depth", 32'(max_occ <= D), 32'd1);
        chk("t2_done_once", 32'(done_cnt - d0), 32'd1);

        // Address wrap: 510, 511, 0, 1
        b = rx_q.size(); d0 = done_cnt; a0 = addr_q.size();
        start_burst(9'd510, 10'd4, sc);
        wait_done("t3_done_seen", d0, 100);
        repeat (2) @(posedge clock);
        #1;
        chk("t3_nreads", 32'(addr_q.size() - a0), 32'd4);
        chk("t3_addr0", 32'(addr_q[a0]),   32'd510);
        chk("t3_addr1", 32'(addr_q[a0+1]), 32'd511);
        chk("t3_addr2", 32'(addr_q[a0+2]), 32'd0);
        chk("t3_addr3", 32'(addr_q[a0+3]), 32'd1);
        chk("t3_count", 32'(rx_q.size() - b), 32'd4);
        chk("t3_word0", rx_q[b],   32'd5100);
        chk("t3_word1", rx_q[b+1], 32'd5110);
        chk("t3_word2", rx_q[b+2], 32'd0);
        chk("t3_word3", rx_q[b+3], 32'd10);
        chk("t3_last_pos", 32'(rx_last_q[b+3]), 32'd1);
        chk("t3_not_last2", 32'(rx_last_q[b+2]), 32'd0);

        // Zero-length burst
        d0 = done_cnt; e0 = en_cnt; v0 = vld_cnt;
        start_burst(9'd7, 10'd0, sc);
        @(negedge clock);
        chk("t4_done_now", 32'(done), 32'd1);
        chk("t4_busy_now", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        repeat (5) @(posedge clock);
        #1;
        chk("t4_done_cyc", 32'(done_cyc), 32'(sc + 1));
        chk("t4_no_reads", 32'(en_cnt - e0), 32'd0);
        chk("t4_no_valid", 32'(vld_cnt - v0), 32'd0);
        chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t4_busy_after", 32'(busy), 32'd0);

        // Ignored second start, then reset after the fourth word
        b = rx_q.size(); d0 = done_cnt;
        start_burst(9'd0, 10'd10, sc);
        repeat (2) @(posedge clock);
        #1;
        start = 1'b1; start_address = 9'd100; length = 10'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int j = 0; j < 100 && (rx_q.size() - b) < 4; j++) begin
            @(posedge clock);
            #1;
        end
        chk("t5_four_words", 32'(rx_q.size() - b), 32'd4);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("t5_rst");
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_words_before_rst", 32'(rx_q.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_pre%0d", i), rx_q[b+i], 32'(i * 10));
        b = rx_q.size(); d0 = done_cnt;
        start_burst(9'd5, 10'd3, sc);
        wait_done("t5_done_seen", d0, 100);
        repeat (2) @(posedge clock);
        #1;
        chk("t5_count", 32'(rx_q.size() - b), 32'd3);
        chk("t5_word0", rx_q[b],   32'd50);
        chk("t5_word1", rx_q[b+1], 32'd60);
        chk("t5_word2", rx_q[b+2], 32'd70);
        chk("t5_last", 32'(rx_last_q[b+2]), 32'd1);
        chk("t5_done_once", 32'(done_cnt - d0), 32'd1);

        // Full-memory burst at one word per cycle
        b = rx_q.size(); d0 = done_cnt;
        start_burst(9'd0, 10'd512, sc);
        wait_done("t6_done_seen", d0, 800);
        repeat (2) @(posedge clock);
        #1;
        chk("t6_count", 32'(rx_q.size() - b), 32'd512);
        errs = 0; nlast = 0;
        for (int i = 0; i < 512; i++) begin
            if (rx_q[b+i] !== 32'(i * 10)) errs++;
            nlast += int'(rx_last_q[b+i]);
        end
        chk("t6_data_errs", 32'(errs), 32'd0);
        chk("t6_nlast", 32'(nlast), 32'd1);
        chk("t6_last_on_511", 32'(rx_last_q[b+511]), 32'd1);
        chk("t6_first_hs_cyc", 32'(rx_cyc_q[b]), 32'(sc + 3));
        chk("t6_span", 32'(rx_cyc_q[b+511] - rx_cyc_q[b]), 32'd511);
        chk("t6_wen_never", 32'(we_seen), 32'd0);
        chk("t6_occ_le_depth", 32'(max_occ <= D), 32'd1);
        chk("t6_done_once", 32'(done_cnt - d0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
